// File: rtl/keypad_reader.sv
// Keypad scanner consumer: acknowledges each presented code, suppresses auto-repeat
// while a key is held, and queues distinct presses in a show-ahead FIFO for the CPU.
module keypad_reader #(
  parameter int DEPTH          = 8,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               key_in,
  input  logic                     key_ready,
  output logic                     key_read,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RELEASE_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACK  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]    state;
  logic [7:0]    held_code;
  logic [RW-1:0] rel_cnt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic capture, push_req, pop, push_ok, ovf_set;

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    capture  = 1'b0;
    push_req = 1'b0;
    if ((state == IDLE || state == HOLD) && key_ready) begin
      capture  = 1'b1;
      push_req = (key_in != '0) && (state == IDLE || key_in != held_code);
    end
    pop     = rd_en && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    push_ok = push_req && (!full || pop);
    ovf_set = push_req && full && !pop;
  end

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_data = empty ? 8'd0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_read  <= 1'b0;
      held_code <= '0;
      rel_cnt   <= '0;
    end else if (capture) begin
      state    <= ACK;
      key_read <= 1'b1;
      if (key_in != '0) held_code <= key_in;
    end else begin
      case (state)
        ACK: begin
          if (!key_ready) begin
            state    <= HOLD;
            key_read <= 1'b0;
            rel_cnt  <= '0;
          end
        end
        HOLD: begin
          if (rel_cnt == RW'(RELEASE_CYCLES - 1)) begin
            state     <= IDLE;
            held_code <= '0;
          end else begin
            rel_cnt <= rel_cnt + RW'(1);
          end
        end
        IDLE: ;
        default: begin
          state    <= IDLE;
          key_read <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (ovf_set)           overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // NOTE: storage is left unreset; count gates rd_data so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= key_in;
  end

endmodule
